// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// clock_mode_ctrl : debounced button front end and RUN/SET/COMMIT sequencer
// Rev 1.0
// ============================================================================
module clock_mode_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 600,
  parameter int CNT_W        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn_raw,
  input  logic       inc_btn_raw,
  input  logic       sel_btn_raw,
  input  logic       set_ack,
  input  logic       alarm_ack,
  output logic       set_time_en,
  output logic       set_alarm_en,
  output logic       mode_pulse,
  output logic       inc_pulse,
  output logic       load_time,
  output logic       load_alarm,
  output logic       timeout_flag,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_SET_TIME  = 2'd1;
  localparam logic [1:0] ST_SET_ALARM = 2'd2;
  localparam logic [1:0] ST_COMMIT    = 2'd3;

  localparam logic [CNT_W-1:0] C_DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0] w_raw;
  logic [2:0] w_prs;
  assign w_raw = {sel_btn_raw, inc_btn_raw, mode_btn_raw};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             level_q;
      logic             prs_q;
      logic [CNT_W-1:0] dbc_q;

      // Level flips only after DEBOUNCE_CYC consecutive disagreeing cycles.
      always_ff @(posedge clk) begin
        if (!rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          level_q <= 1'b0;
          prs_q   <= 1'b0;
          dbc_q   <= '0;
        end else begin
          sync1_q <= w_raw[gi];
          sync2_q <= sync1_q;
          prs_q   <= 1'b0;
          if (sync2_q != level_q) begin
            if (dbc_q == C_DB_LAST) begin
              level_q <= sync2_q;
              prs_q   <= sync2_q;
              dbc_q   <= '0;
            end else begin
              dbc_q <= dbc_q + CNT_W'(1);
            end
          end else begin
            dbc_q <= '0;
          end
        end
      end

      assign w_prs[gi] = prs_q;
    end
  endgenerate

  logic w_prs_mode, w_prs_inc, w_prs_sel;
  assign w_prs_mode = w_prs[0];
  assign w_prs_inc  = w_prs[1];
  assign w_prs_sel  = w_prs[2];

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             pend_q, pend_d;
  logic             mode_pulse_q, mode_pulse_d;
  logic             inc_pulse_q, inc_pulse_d;
  logic             load_time_q, load_time_d;
  logic             load_alarm_q, load_alarm_d;
  logic             timeout_q, timeout_d;
  logic             w_ack;

  assign w_ack = (state_q == ST_SET_TIME) ? set_ack : alarm_ack;

  // A confirming mode press is forwarded while still in SET_*, then the
  // pending flag moves the FSM to COMMIT on the following cycle so the
  // forwarded pulse never lands outside its enable.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    pend_d       = 1'b0;
    mode_pulse_d = 1'b0;
    inc_pulse_d  = 1'b0;
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (w_prs_mode) begin
          state_d = ST_SET_TIME;
          tmo_d   = '0;
        end else if (w_prs_sel) begin
          state_d = ST_SET_ALARM;
          tmo_d   = '0;
        end
      end
      ST_SET_TIME, ST_SET_ALARM: begin
        if (pend_q) begin
          state_d      = ST_COMMIT;
          load_time_d  = (state_q == ST_SET_TIME);
          load_alarm_d = (state_q == ST_SET_ALARM);
        end else if (w_prs_mode) begin
          mode_pulse_d = 1'b1;
          tmo_d        = '0;
          pend_d       = w_ack;
        end else if (w_prs_inc) begin
          inc_pulse_d = 1'b1;
          tmo_d       = '0;
        end else if (tmo_q == C_TMO_LAST) begin
          state_d   = ST_RUN;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      tmo_q        <= '0;
      pend_q       <= 1'b0;
      mode_pulse_q <= 1'b0;
      inc_pulse_q  <= 1'b0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      pend_q       <= pend_d;
      mode_pulse_q <= mode_pulse_d;
      inc_pulse_q  <= inc_pulse_d;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      timeout_q    <= timeout_d;
    end
  end

  assign set_time_en  = (state_q == ST_SET_TIME);
  assign set_alarm_en = (state_q == ST_SET_ALARM);
  assign mode_pulse   = mode_pulse_q;
  assign inc_pulse    = inc_pulse_q;
  assign load_time    = load_time_q;
  assign load_alarm   = load_alarm_q;
  assign timeout_flag = timeout_q;
  assign state_o      = state_q;

endmodule
`default_nettype wire
